// File: rtl/ex_issue_stage_if.sv
//------------------------------------------------------------------------------
// ex_issue_stage_if : ID/bypass/EX signal bundle around the ID/EX issue stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ex_issue_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    // ID side
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [2:0]        id_funct3;
    logic              id_funct7b5;
    logic              id_is_imm;
    logic              id_add_only;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic              id_reg_write;
    logic              id_is_load;
    // Bypass sources
    logic              exm_valid;
    logic              exm_reg_write;
    logic              exm_is_load;
    logic [REG_AW-1:0] exm_rd;
    logic [XLEN-1:0]   exm_result;
    logic              mwb_valid;
    logic              mwb_reg_write;
    logic [REG_AW-1:0] mwb_rd;
    logic [XLEN-1:0]   mwb_result;
    // EX side
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_alu_da;
    logic [XLEN-1:0]   ex_alu_db;
    logic [3:0]        ex_alu_ctl;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs2_fwd;

    modport slave (
        input  flush,
        input  id_valid, id_pc, id_funct3, id_funct7b5, id_is_imm, id_add_only,
        input  id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_rd,
        input  id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_is_load,
        input  exm_valid, exm_reg_write, exm_is_load, exm_rd, exm_result,
        input  mwb_valid, mwb_reg_write, mwb_rd, mwb_result,
        input  ex_ready,
        output id_ready,
        output ex_valid, ex_alu_da, ex_alu_db, ex_alu_ctl, ex_rd,
        output ex_reg_write, ex_is_load, ex_pc, ex_rs2_fwd
    );

    modport master (
        output flush,
        output id_valid, id_pc, id_funct3, id_funct7b5, id_is_imm, id_add_only,
        output id_use_rs1, id_use_rs2, id_rs1, id_rs2, id_rd,
        output id_rs1_data, id_rs2_data, id_imm, id_reg_write, id_is_load,
        output exm_valid, exm_reg_write, exm_is_load, exm_rd, exm_result,
        output mwb_valid, mwb_reg_write, mwb_rd, mwb_result,
        output ex_ready,
        input  id_ready,
        input  ex_valid, ex_alu_da, ex_alu_db, ex_alu_ctl, ex_rd,
        input  ex_reg_write, ex_is_load, ex_pc, ex_rs2_fwd
    );
endinterface

`default_nettype wire

// File: rtl/ex_issue_stage.sv
//------------------------------------------------------------------------------
// ex_issue_stage : one-entry ID/EX register with ALU encode, bypass, load-use.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_issue_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ex_issue_stage_if.slave    bus
);
    localparam logic [3:0] C_ALU_ADD  = 4'b0000;
    localparam logic [3:0] C_ALU_SUB  = 4'b0001;
    localparam logic [3:0] C_ALU_SLL  = 4'b0101;
    localparam logic [3:0] C_ALU_SLT  = 4'b1001;
    localparam logic [3:0] C_ALU_SLTU = 4'b1010;
    localparam logic [3:0] C_ALU_XOR  = 4'b1110;
    localparam logic [3:0] C_ALU_SRL  = 4'b0110;
    localparam logic [3:0] C_ALU_SRA  = 4'b0111;
    localparam logic [3:0] C_ALU_OR   = 4'b1101;
    localparam logic [3:0] C_ALU_AND  = 4'b1100;

    function automatic logic [3:0] enc_ctl(input logic [2:0] f3, input logic f7b5,
                                           input logic is_imm, input logic add_only);
        logic [3:0] ctl;
        case (f3)
            3'b000:  ctl = (!is_imm && f7b5) ? C_ALU_SUB : C_ALU_ADD;
            3'b001:  ctl = C_ALU_SLL;
            3'b010:  ctl = C_ALU_SLT;
            3'b011:  ctl = C_ALU_SLTU;
            3'b100:  ctl = C_ALU_XOR;
            3'b101:  ctl = f7b5 ? C_ALU_SRA : C_ALU_SRL;
            3'b110:  ctl = C_ALU_OR;
            default: ctl = C_ALU_AND;
        endcase
        return add_only ? C_ALU_ADD : ctl;
    endfunction

    function automatic logic [XLEN-1:0] fwd(
        input logic [REG_AW-1:0] rs,      input logic [XLEN-1:0] held,
        input logic              exm_en,  input logic [REG_AW-1:0] exm_rd,
        input logic [XLEN-1:0]   exm_res, input logic mwb_en,
        input logic [REG_AW-1:0] mwb_rd,  input logic [XLEN-1:0] mwb_res);
        if (rs == '0)                       return '0;
        else if (exm_en && exm_rd == rs)    return exm_res;
        else if (mwb_en && mwb_rd == rs)    return mwb_res;
        else                                return held;
    endfunction

    logic              hv_q, hv_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [3:0]        ctl_q, ctl_d;
    logic              is_imm_q, is_imm_d;
    logic              use_rs1_q, use_rs1_d;
    logic              use_rs2_q, use_rs2_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic              reg_write_q, reg_write_d;
    logic              is_load_q, is_load_d;

    logic              exm_en, mwb_en, hz, ex_valid, fire, id_ready, capture;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

    // Loads in EX/MEM have no data yet, so they never bypass and instead stall.
    assign exm_en  = bus.exm_valid & bus.exm_reg_write & ~bus.exm_is_load;
    assign mwb_en  = bus.mwb_valid & bus.mwb_reg_write;
    assign fwd_rs1 = fwd(rs1_q, rs1_data_q, exm_en, bus.exm_rd, bus.exm_result,
                         mwb_en, bus.mwb_rd, bus.mwb_result);
    assign fwd_rs2 = fwd(rs2_q, rs2_data_q, exm_en, bus.exm_rd, bus.exm_result,
                         mwb_en, bus.mwb_rd, bus.mwb_result);

    assign hz = hv_q & bus.exm_valid & bus.exm_is_load & bus.exm_reg_write &
                (bus.exm_rd != '0) &
                ((use_rs1_q & (bus.exm_rd == rs1_q)) | (use_rs2_q & (bus.exm_rd == rs2_q)));
    assign ex_valid = hv_q & ~hz & ~bus.flush;
    assign fire     = ex_valid & bus.ex_ready;
    assign id_ready = ~hv_q | fire;
    assign capture  = bus.id_valid & id_ready & ~bus.flush;

    always_comb begin
        hv_d        = hv_q;
        pc_d        = pc_q;
        ctl_d       = ctl_q;
        is_imm_d    = is_imm_q;
        use_rs1_d   = use_rs1_q;
        use_rs2_d   = use_rs2_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        reg_write_d = reg_write_q;
        is_load_d   = is_load_q;
        if (bus.flush) begin
            hv_d = 1'b0;
        end else if (capture) begin
            hv_d        = 1'b1;
            pc_d        = bus.id_pc;
            ctl_d       = enc_ctl(bus.id_funct3, bus.id_funct7b5, bus.id_is_imm, bus.id_add_only);
            is_imm_d    = bus.id_is_imm;
            use_rs1_d   = bus.id_use_rs1;
            use_rs2_d   = bus.id_use_rs2;
            rs1_d       = bus.id_rs1;
            rs2_d       = bus.id_rs2;
            rd_d        = bus.id_rd;
            rs1_data_d  = bus.id_rs1_data;
            rs2_data_d  = bus.id_rs2_data;
            imm_d       = bus.id_imm;
            reg_write_d = bus.id_reg_write;
            is_load_d   = bus.id_is_load;
        end else if (fire) begin
            hv_d = 1'b0;
        end
        // A stalled instruction latches its bypassed operands so they survive
        // the producer leaving the pipeline.
        if (hv_q && !fire && !capture) begin
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q        <= 1'b0;
            pc_q        <= '0;
            ctl_q       <= '0;
            is_imm_q    <= 1'b0;
            use_rs1_q   <= 1'b0;
            use_rs2_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            hv_q        <= hv_d;
            pc_q        <= pc_d;
            ctl_q       <= ctl_d;
            is_imm_q    <= is_imm_d;
            use_rs1_q   <= use_rs1_d;
            use_rs2_q   <= use_rs2_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            reg_write_q <= reg_write_d;
            is_load_q   <= is_load_d;
        end
    end

    assign bus.id_ready     = id_ready;
    assign bus.ex_valid     = ex_valid;
    assign bus.ex_alu_da    = fwd_rs1;
    assign bus.ex_alu_db    = is_imm_q ? imm_q : fwd_rs2;
    assign bus.ex_rs2_fwd   = fwd_rs2;
    assign bus.ex_alu_ctl   = ctl_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = reg_write_q;
    assign bus.ex_is_load   = is_load_q;
    assign bus.ex_pc        = pc_q;

endmodule

`default_nettype wire

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the integer ALU.
- Accepts one decoded instruction per cycle from ID over a valid/ready handshake and holds it in a one-entry register.
- Encodes the 4-bit ALU control word and resolves operand forwarding from EX/MEM and MEM/WB.
- Inserts load-use bubbles, then presents ALU_DA/ALU_DB/ALU_CTL plus sideband to EX.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kills held and incoming instruction.
- id_valid  in  1  ID offers an instruction.
- id_ready  out  1  stage can accept.
- id_pc  in  XLEN  instruction PC.
- id_funct3  in  3  funct3 field.
- id_funct7b5  in  1  instr bit 30.
- id_is_imm  in  1  DB from immediate.
- id_add_only  in  1  force ADD (load/store/jalr address).
- id_use_rs1, id_use_rs2  in  1 each  operand actually read.
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN each  regfile reads, sign-extended immediate.
- id_reg_write, id_is_load  in  1 each  sideband.
- exm_valid, exm_reg_write, exm_is_load  in  1 each  EX/MEM slot status.
- exm_rd  in  REG_AW  EX/MEM destination.
- exm_result  in  XLEN  EX/MEM ALU result.
- mwb_valid, mwb_reg_write  in  1 each  MEM/WB slot status.
- mwb_rd  in  REG_AW  MEM/WB destination.
- mwb_result  in  XLEN  MEM/WB writeback value.
- ex_valid  out  1  operands valid for EX.
- ex_ready  in  1  EX accepts.
- ex_alu_da, ex_alu_db  out  XLEN each  ALU operands.
- ex_alu_ctl  out  4  ALU control word.
- ex_rd  out  REG_AW  destination index.
- ex_reg_write, ex_is_load  out  1 each  sideband.
- ex_pc  out  XLEN  PC passthrough.
- ex_rs2_fwd  out  XLEN  forwarded rs2, used as store data.

Behaviour:
- State: held-valid bit hv, plus registered copies of every id_* field.
- Reset (async, rst_n=0): hv=0. All registered fields are cleared to 0, so ex_valid=0, ex_alu_ctl=0000 and every data output is 0.
- ALU_CTL is encoded at capture, using funct3:
  - 000: ADD 0000, or SUB 0001 when !is_imm & funct7b5.
  - 001: SLL 0101.
  - 010: SLT 1001.
  - 011: SLTU 1010.
  - 100: XOR 1110.
  - 101: SRL 0110, or SRA 0111 when funct7b5 (immediate form included).
  - 110: OR 1101.
  - 111: AND 1100.
  - id_add_only=1 overrides to 0000.
- Forwarding is combinational on held operands, per rs, with highest priority first:
  1. EX/MEM hit: exm_valid & exm_reg_write & exm_rd==rs & rs!=0 & !exm_is_load → exm_result.
  2. MEM/WB hit: same conditions on the mwb_* signals → mwb_result.
  3. Otherwise the held regfile data.
  - rs==0 always yields 0.
- ex_alu_da = fwd rs1. ex_alu_db = held imm if is_imm, else fwd rs2. ex_rs2_fwd = fwd rs2 always.
- Load-use hazard: hz = hv & exm_valid & exm_is_load & exm_reg_write & exm_rd!=0 & ((use_rs1 & exm_rd==rs1) | (use_rs2 & exm_rd==rs2)).
- ex_valid = hv & !hz & !flush.
- Fire: fire = ex_valid & ex_ready.
- id_ready = !hv | fire. This gives full throughput with no bubble when EX accepts every cycle.
- Capture: id_valid & id_ready & !flush → load the register, hv=1. Otherwise, fire → hv=0.
- Refresh: each cycle hv=1 and the instruction does not fire, overwrite held rs1/rs2 data with their current forwarded values. This preserves bypassed values across stalls of any length.
- Flush has priority over everything: next hv=0, the incoming instruction is dropped, and ex_valid is 0 in the flush cycle.
- Simultaneous fire and capture in one cycle: the new instruction replaces the old one; hv stays 1.
- Latency: one cycle from ID handshake to ex_valid when no hazard.

Test Plan:
- Reset: hold rst_n=0 mid-run with hv=1 → ex_valid=0 and ex_alu_ctl=0000 immediately (async), without waiting for a clock edge.
- Encoding: R-type funct3=000 funct7b5=1 → ctl 0001. I-type funct3=000 funct7b5=1 → 0000. funct3=101 funct7b5=1 → 0111. funct3=011 → 1010. add_only with funct3=110 → 0000.
- Forwarding: held rs1=5 (regfile 0x11); exm hit rd=5 result 0x22 and mwb hit rd=5 result 0x33 → DA=0x22. Drop exm → DA=0x33. rs1=0 with both hits → DA=0.
- Load-use: held use_rs2, rs2=7, exm_is_load rd=7 → ex_valid=0 for one cycle. Next cycle mwb rd=7 result 0xDEAD → ex_valid=1, DB=0xDEAD.
- Stall refresh: ex_ready=0 for 3 cycles while mwb forwards 0x44 to rs1 only in cycle 1 → DA stays 0x44 in cycles 2-3 and at fire.
- Throughput and flush: back-to-back id_valid with ex_ready=1 → one instruction per cycle, id_ready constantly 1. Assert flush with id_valid=1 → ex_valid=0 in the flush cycle and next cycle, and that instruction never appears at EX.
